rx: RTL

// - UART receiver; counterpart of the team's parity-enabled UART transmitter.
// - Frame: start(0), 8 data bits LSB first, parity, stop(1); even/odd parity selected per frame.
// - Sits between the FPGA serial RX pin and the I/O system; delivers a byte plus error flags as a one-cycle strobe.

---
 rtl/rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; even/odd parity chosen per frame.
// Define RX_MAJORITY_VOTE_EN to take every sample point as a 2-of-3 majority vote.
module rx #(
  parameter int unsigned CLK_FREQUENCY = 100000000,
  parameter int unsigned BAUD_RATE     = 19200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       odd,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF_BIT   = BIT_CYCLES / 2;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int unsigned VOTE_OFF   = BIT_CYCLES / 16;
  // Room for the late vote past the bit centre.
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES) + 1;
`else
  localparam int unsigned VOTE_OFF   = 0;
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES);
`endif

  localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_TGT  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] VOTE_C   = CNT_W'(VOTE_OFF);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             odd_q;
  logic             par_q;
  logic [CNT_W-1:0] target;
  logic             sample_now;
  logic             sample_val;
`ifdef RX_MAJORITY_VOTE_EN
  logic             v0_q;
  logic             v1_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  assign rx_s = sync_q[1];
  assign busy = (state_q != StIdle);

  // Centre of the bit is at cnt == target; the timer restarts as if it had been cleared there.
  always_comb begin
    target = (state_q == StStart) ? HALF_TGT : BIT_TGT;
`ifdef RX_MAJORITY_VOTE_EN
    sample_now = (cnt_q == target + VOTE_C);
    sample_val = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
`else
    sample_now = (cnt_q == target);
    sample_val = rx_s;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      odd_q         <= 1'b0;
      par_q         <= 1'b0;
      dout          <= '0;
      data_strobe   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
      v0_q          <= 1'b1;
      v1_q          <= 1'b1;
`endif
    end else begin
      data_strobe <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
      if (cnt_q == target - VOTE_C) v0_q <= rx_s;
      if (cnt_q == target)          v1_q <= rx_s;
`endif
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= StStart;
        end
        StStart: begin
          if (sample_now) begin
            if (!sample_val) begin
              odd_q     <= odd;
              cnt_q     <= VOTE_C;
              bit_idx_q <= '0;
              state_q   <= StData;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StData: begin
          if (sample_now) begin
            shreg_q   <= {sample_val, shreg_q[7:1]};
            cnt_q     <= VOTE_C;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StParity;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StParity: begin
          if (sample_now) begin
            par_q   <= sample_val;
            cnt_q   <= VOTE_C;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StStop: begin
          if (sample_now) begin
            dout          <= shreg_q;
            parity_error  <= ((^shreg_q) ^ par_q) != odd_q;
            framing_error <= ~sample_val;
            data_strobe   <= 1'b1;
            cnt_q         <= '0;
            state_q       <= sample_val ? StIdle : StWaitHigh;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWaitHigh: begin
          // A held-low line (break) must return high before another start is accepted.
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
